// File: rtl/branch_resolver.sv
//==============================================================================
// Module      : branch_resolver
// Description : Resolves conditional branches. It decodes the branch type from
//               funct3, combines it with the external comparator flags, and
//               computes the target pc+imm. Taken, aligned branches emit a
//               one-cycle redirect and start a pipeline flush. Misaligned
//               targets and illegal funct3 codes each raise a one-cycle
//               exception pulse. It also keeps accepted/taken branch counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   FLUSH_CYCLES    : flush length after a redirect, 1..7
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-high reset
//   branch_valid    : branch instruction presented this cycle
//   funct3          : branch type field
//   pc              : branch instruction address
//   imm             : sign-extended branch offset
//   stall           : hold, no acceptance this cycle
//   branch_equal    : comparator equal flag
//   branch_lessthan : comparator less-than flag
//   branch_unsigned : comparator signedness select (funct3[1])
//   redirect_valid  : one-cycle PC redirect pulse
//   redirect_target : new PC, held between redirects
//   flush           : squash younger instructions
//   misaligned      : one-cycle target-misaligned exception pulse
//   illegal_branch  : one-cycle illegal-funct3 pulse
//   branch_count    : legal accepted branches
//   taken_count     : taken branches, including misaligned ones
//==============================================================================
`default_nettype none

module branch_resolver #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_valid,
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        stall,
    input  logic        branch_equal,
    input  logic        branch_lessthan,
    output logic        branch_unsigned,
    output logic        redirect_valid,
    output logic [31:0] redirect_target,
    output logic        flush,
    output logic        misaligned,
    output logic        illegal_branch,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    // Counter load value: the redirect edge already starts the first flush
    // cycle, so the countdown covers the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    // S_RESUME is the single cycle following the flush exit, during which a
    // presented branch is still ignored.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_RESUME = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_flush_cnt;

    logic        w_accept;
    logic        w_illegal;
    logic        w_taken;
    logic [31:0] w_target;

    assign branch_unsigned = funct3[1];

    assign w_accept  = branch_valid && !stall && (r_state == S_IDLE);
    assign w_illegal = (funct3[2:1] == 2'b01);
    assign w_target  = pc + imm;

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = branch_equal;
            3'b001:  w_taken = !branch_equal;
            3'b100,
            3'b110:  w_taken = branch_lessthan;
            3'b101,
            3'b111:  w_taken = !branch_lessthan;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_flush_cnt     <= 3'd0;
            redirect_valid  <= 1'b0;
            redirect_target <= 32'd0;
            flush           <= 1'b0;
            misaligned      <= 1'b0;
            illegal_branch  <= 1'b0;
            branch_count    <= 32'd0;
            taken_count     <= 32'd0;
        end else begin
            redirect_valid <= 1'b0;
            misaligned     <= 1'b0;
            illegal_branch <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            illegal_branch <= 1'b1;
                        end else begin
                            branch_count <= branch_count + 32'd1;
                            if (w_taken) begin
                                taken_count <= taken_count + 32'd1;
                                if (w_target[1:0] == 2'b00) begin
                                    redirect_valid  <= 1'b1;
                                    redirect_target <= w_target;
                                    flush           <= 1'b1;
                                    r_flush_cnt     <= C_FLUSH_LOAD;
                                    r_state         <= S_FLUSH;
                                end else begin
                                    misaligned <= 1'b1;
                                end
                            end
                        end
                    end
                end

                // Stall is deliberately not consulted: the flush always runs
                // its full length.
                S_FLUSH: begin
                    if (r_flush_cnt == 3'd0) begin
                        flush   <= 1'b0;
                        r_state <= S_RESUME;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end

                S_RESUME: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    flush   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
//==============================================================================
// Module      : tb_branch_resolver
// Description : Self-checking bench for branch_resolver. Each driven cycle
//               computes the expected registered outputs from a behavioural
//               model and queues them; they are popped and compared after
//               the following rising edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_resolver;

    localparam int FLUSH_CYCLES = 2;

    logic        clk;
    logic        rst;
    logic        branch_valid;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        stall;
    logic        branch_equal;
    logic        branch_lessthan;
    logic        branch_unsigned;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        flush;
    logic        misaligned;
    logic        illegal_branch;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_valid    (branch_valid),
        .funct3          (funct3),
        .pc              (pc),
        .imm             (imm),
        .stall           (stall),
        .branch_equal    (branch_equal),
        .branch_lessthan (branch_lessthan),
        .branch_unsigned (branch_unsigned),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .flush           (flush),
        .misaligned      (misaligned),
        .illegal_branch  (illegal_branch),
        .branch_count    (branch_count),
        .taken_count     (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        fl;
        logic        mis;
        logic        ill;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t q_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 idle, 1 flushing, 2 one-cycle hold after flush exit
    int          m_state = 0;
    int          m_left  = 0;
    logic [31:0] m_bc    = 0;
    logic [31:0] m_tc    = 0;
    logic [31:0] m_tgt   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_bc    = 0;
        m_tc    = 0;
        m_tgt   = 0;
        q_exp.delete();
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = q_exp.pop_front();
        check({tag, "_rv"},    {31'd0, redirect_valid}, {31'd0, e.rv});
        check({tag, "_tgt"},   redirect_target,         e.tgt);
        check({tag, "_flush"}, {31'd0, flush},          {31'd0, e.fl});
        check({tag, "_mis"},   {31'd0, misaligned},     {31'd0, e.mis});
        check({tag, "_ill"},   {31'd0, illegal_branch}, {31'd0, e.ill});
        check({tag, "_bc"},    branch_count,            e.bc);
        check({tag, "_tc"},    taken_count,             e.tc);
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then
    // compare them just after the edge.
    task automatic step(input string tag, input logic v, input logic [2:0] f3,
                        input logic [31:0] p, input logic [31:0] im,
                        input logic st, input logic eq, input logic lt);
        exp_t        e;
        logic        acc;
        logic        tk;
        logic        legal;
        logic [31:0] t;
        branch_valid    = v;
        funct3          = f3;
        pc              = p;
        imm             = im;
        stall           = st;
        branch_equal    = eq;
        branch_lessthan = lt;

        acc   = v && !st && (m_state == 0);
        legal = !(f3 == 3'b010 || f3 == 3'b011);
        unique case (f3)
            3'b000:  tk = eq;
            3'b001:  tk = !eq;
            3'b100:  tk = lt;
            3'b110:  tk = lt;
            3'b101:  tk = !lt;
            3'b111:  tk = !lt;
            default: tk = 1'b0;
        endcase
        t = p + im;

        e.rv  = 1'b0;
        e.mis = 1'b0;
        e.ill = 1'b0;

        if (m_state == 1) begin
            if (m_left == 1) m_state = 2;
            else             m_left  = m_left - 1;
        end else if (m_state == 2) begin
            m_state = 0;
        end

        if (acc) begin
            if (!legal) begin
                e.ill = 1'b1;
            end else begin
                m_bc = m_bc + 1;
                if (tk) begin
                    m_tc = m_tc + 1;
                    if (t[1:0] == 2'b00) begin
                        e.rv    = 1'b1;
                        m_tgt   = t;
                        m_state = 1;
                        m_left  = FLUSH_CYCLES;
                    end else begin
                        e.mis = 1'b1;
                    end
                end
            end
        end
        e.fl  = (m_state == 1);
        e.tgt = m_tgt;
        e.bc  = m_bc;
        e.tc  = m_tc;
        q_exp.push_back(e);

        #1;
        check({tag, "_bu"}, {31'd0, branch_unsigned}, {31'd0, f3[1]});
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst             = 1'b1;
        branch_valid    = 1'b0;
        funct3          = 3'b000;
        pc              = 32'd0;
        imm             = 32'd0;
        stall           = 1'b0;
        branch_equal    = 1'b0;
        branch_lessthan = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rv",    {31'd0, redirect_valid}, 32'd0);
        check("rst_tgt",   redirect_target,         32'd0);
        check("rst_flush", {31'd0, flush},          32'd0);
        check("rst_bc",    branch_count,            32'd0);
        check("rst_tc",    taken_count,             32'd0);
        rst = 1'b0;
        model_reset();

        // BEQ taken, aligned: redirect to 0x120, flush for two cycles
        step("beq", 1'b1, 3'b000, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
        idle("beq_fl", 4);

        // BNE with equal=1: not taken
        step("bne_nt", 1'b1, 3'b001, 32'h200, 32'h40, 1'b0, 1'b1, 1'b0);

        // BLTU selects unsigned compare, taken
        step("bltu", 1'b1, 3'b110, 32'h300, 32'h10, 1'b0, 1'b0, 1'b1);
        idle("bltu_fl", 4);

        // BLT with lessthan=0: counted, not taken
        step("blt_nt", 1'b1, 3'b100, 32'h300, 32'h10, 1'b0, 1'b0, 1'b0);

        // BGE / BGEU taken when not less-than
        step("bge", 1'b1, 3'b101, 32'h400, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
        idle("bge_fl", 4);

        // Target wraps past 0xFFFFFFFF
        step("wrap", 1'b1, 3'b000, 32'hFFFF_FFF0, 32'h14, 1'b0, 1'b1, 1'b0);
        idle("wrap_fl", 4);

        // Misaligned target: exception, no redirect, no flush
        step("misal", 1'b1, 3'b000, 32'h100, 32'h2, 1'b0, 1'b1, 1'b0);
        idle("misal_post", 1);

        // Stall blocks acceptance while held, then accepted
        step("stall1", 1'b1, 3'b111, 32'h500, 32'h8, 1'b1, 1'b0, 1'b0);
        step("stall2", 1'b1, 3'b111, 32'h500, 32'h8, 1'b1, 1'b0, 1'b0);
        step("stall_go", 1'b1, 3'b111, 32'h500, 32'h8, 1'b0, 1'b0, 1'b0);

        // Branch held valid through FLUSH (also with stall toggling) and the
        // exit cycle; accepted on the first idle cycle after the exit cycle
        step("hold_fl1", 1'b1, 3'b001, 32'h600, 32'h4, 1'b1, 1'b0, 1'b0);
        step("hold_exit", 1'b1, 3'b001, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0);
        step("hold_rsm", 1'b1, 3'b001, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0);
        step("hold_acc", 1'b1, 3'b001, 32'h600, 32'h4, 1'b0, 1'b0, 1'b0);
        idle("hold_fl", 4);

        // Illegal funct3 codes: pulse, counters unchanged
        step("ill011", 1'b1, 3'b011, 32'h700, 32'h4, 1'b0, 1'b1, 1'b1);
        step("ill010", 1'b1, 3'b010, 32'h700, 32'h4, 1'b0, 1'b0, 1'b0);
        idle("ill_post", 1);

        // Reset asserted during the second FLUSH cycle
        step("rf_acc", 1'b1, 3'b000, 32'h800, 32'h40, 1'b0, 1'b1, 1'b0);
        step("rf_fl2", 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        funct3 = 3'b010;
        #1;
        check("arst_flush", {31'd0, flush},           32'd0);
        check("arst_rv",    {31'd0, redirect_valid},  32'd0);
        check("arst_tgt",   redirect_target,          32'd0);
        check("arst_bc",    branch_count,             32'd0);
        check("arst_tc",    taken_count,              32'd0);
        check("arst_bu",    {31'd0, branch_unsigned}, 32'd1);
        branch_valid = 1'b1;
        funct3       = 3'b000;
        branch_equal = 1'b1;
        @(posedge clk);
        #1;
        check("rsthold_rv", {31'd0, redirect_valid}, 32'd0);
        check("rsthold_bc", branch_count,            32'd0);
        rst = 1'b0;
        model_reset();

        // First acceptance right after reset release
        step("post_rst", 1'b1, 3'b000, 32'h900, 32'h10, 1'b0, 1'b1, 1'b0);
        idle("post_fl", 4);

        if (q_exp.size() != 0) check("queue_drained", q_exp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
